fibo_controller: RTL

FIBO_CONTROLLER -- requirements
Module: fibo_controller

---
 rtl/fibo_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fibo_controller.sv
// Sequencer for a 4-register ring datapath that computes F(n) mod 2^size.
// Optional build macro FIBO_CTRL_ZCHK_EN aborts COMPUTE on an ALU zero result.
module fibo_controller #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [size-1:0] n,
  input  logic            zero_flag,
  output logic            wrt_en,
  output logic [1:0]      wrt_addr,
  output logic [1:0]      rd_addr1,
  output logic [1:0]      rd_addr2,
  output logic            load_data,
  output logic [2:0]      alu_opcode,
  output logic [size-1:0] count,
  output logic            busy,
  output logic            done,
  output logic [1:0]      result_addr,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT0   = 3'd1,
    INIT1   = 3'd2,
    COMPUTE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b110;

  state_t          state_q, state_d;
  logic [size-1:0] n_q, n_d;
  logic [size-1:0] i_q, i_d;
  logic            err_q, err_d;
  logic [1:0]      result_addr_q, result_addr_d;
  logic            wrt_en_q, wrt_en_d;
  logic [1:0]      wrt_addr_q, wrt_addr_d;
  logic [1:0]      rd_addr1_q, rd_addr1_d;
  logic [1:0]      rd_addr2_q, rd_addr2_d;
  logic            load_data_q, load_data_d;
  logic [2:0]      alu_opcode_q, alu_opcode_d;
  logic [size-1:0] count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            abort;

`ifdef FIBO_CTRL_ZCHK_EN
  assign abort = zero_flag;
`else
  logic unused_zero_flag;
  assign unused_zero_flag = zero_flag;
  assign abort            = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    i_d           = i_q;
    err_d         = err_q;
    result_addr_d = result_addr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d           = n;
          err_d         = 1'b0;
          i_d           = size'(2);
          result_addr_d = n[1:0];
          state_d       = INIT0;
        end
      end
      INIT0:   state_d = INIT1;
      INIT1:   state_d = (n_q >= size'(2)) ? COMPUTE : DONE;
      COMPUTE: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (i_q == n_q) begin
          state_d = DONE;
        end else begin
          i_d = i_q + size'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    wrt_en_d     = 1'b0;
    wrt_addr_d   = 2'd0;
    rd_addr1_d   = 2'd0;
    rd_addr2_d   = 2'd0;
    load_data_d  = 1'b0;
    alu_opcode_d = 3'd0;
    count_d      = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state_d)
      INIT0: begin
        wrt_en_d    = 1'b1;
        load_data_d = 1'b1;
        busy_d      = 1'b1;
      end
      INIT1: begin
        wrt_en_d    = 1'b1;
        load_data_d = 1'b1;
        wrt_addr_d  = 2'd1;
        count_d     = size'(1);
        busy_d      = 1'b1;
      end
      COMPUTE: begin
        wrt_en_d     = 1'b1;
        alu_opcode_d = ALU_ADD;
        wrt_addr_d   = i_d[1:0];
        rd_addr1_d   = i_d[1:0] - 2'd1;
        rd_addr2_d   = i_d[1:0] - 2'd2;
        busy_d       = 1'b1;
      end
      DONE: begin
        done_d     = 1'b1;
        rd_addr1_d = result_addr_d;
        rd_addr2_d = result_addr_d;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      n_q           <= '0;
      i_q           <= '0;
      err_q         <= 1'b0;
      result_addr_q <= 2'd0;
      wrt_en_q      <= 1'b0;
      wrt_addr_q    <= 2'd0;
      rd_addr1_q    <= 2'd0;
      rd_addr2_q    <= 2'd0;
      load_data_q   <= 1'b0;
      alu_opcode_q  <= 3'd0;
      count_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      i_q           <= i_d;
      err_q         <= err_d;
      result_addr_q <= result_addr_d;
      wrt_en_q      <= wrt_en_d;
      wrt_addr_q    <= wrt_addr_d;
      rd_addr1_q    <= rd_addr1_d;
      rd_addr2_q    <= rd_addr2_d;
      load_data_q   <= load_data_d;
      alu_opcode_q  <= alu_opcode_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign wrt_en      = wrt_en_q;
  assign wrt_addr    = wrt_addr_q;
  assign rd_addr1    = rd_addr1_q;
  assign rd_addr2    = rd_addr2_q;
  assign load_data   = load_data_q;
  assign alu_opcode  = alu_opcode_q;
  assign count       = count_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result_addr = result_addr_q;
  assign err         = err_q;

endmodule
